morse_receiver: RTL

- Receiving end of the letter-to-Morse serial link: samples a one-bit Morse line, recovers the 14-bit unit pattern, and decodes it back to the 3-bit letter index.
- Line format: one unit per bit, MSB (code[13]) sent first, line idle low.
- Sits between a debounced/pin input (or a transmitter output in loopback) and LEDR/HEX display logic.

---
 rtl/morse_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/morse_receiver.sv
// Morse line receiver: synchronises a one-bit Morse line, samples 14 units mid-unit,
// and decodes the captured pattern to a 3-bit letter index.
module morse_receiver #(
    parameter int unsigned UNIT_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 28
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        morse_in,
    output logic [2:0]  letter,
    output logic [13:0] code,
    output logic        valid,
    output logic        error,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StCapture, StDecode, StGap} state_e;

    // First sample lands 1.5 units after the leading edge, i.e. mid-way through unit 1.
    localparam logic [CNT_W-1:0] LoadFirst = CNT_W'(UNIT_CYCLES + UNIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] LoadUnit  = CNT_W'(UNIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        sync_q, sync_d;
    logic [CNT_W-1:0]  div_q, div_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [13:0]       sr_q, sr_d;
    logic [2:0]        letter_q, letter_d;
    logic [13:0]       code_q, code_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;

    logic              morse_s;
    logic              tick;
    logic              dec_hit;
    logic [2:0]        dec_letter;

    assign sync_d  = {sync_q[0], morse_in};
    assign morse_s = sync_q[1];
    assign tick    = (div_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sync_q    <= 2'b00;
            div_q     <= '0;
            bit_cnt_q <= 4'd0;
            sr_q      <= 14'd0;
            letter_q  <= 3'd0;
            code_q    <= 14'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            letter_q  <= letter_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (morse_s) state_d = StCapture;
            StCapture: if (tick && bit_cnt_q == 4'd13) state_d = StDecode;
            StDecode:  state_d = StGap;
            StGap:     if (!morse_s && div_q == '0) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        dec_hit    = 1'b1;
        dec_letter = 3'd0;
        case (sr_q)
            14'b10101000000000: dec_letter = 3'd0;
            14'b11100000000000: dec_letter = 3'd1;
            14'b10101110000000: dec_letter = 3'd2;
            14'b10101011100000: dec_letter = 3'd3;
            14'b10111011100000: dec_letter = 3'd4;
            14'b11101010111000: dec_letter = 3'd5;
            14'b11101011101110: dec_letter = 3'd6;
            14'b11101110101000: dec_letter = 3'd7;
            default:            dec_hit    = 1'b0;
        endcase
    end

    // The divider doubles as the gap counter once the pattern has been decoded.
    always_comb begin
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        letter_d  = letter_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (morse_s) begin
                    sr_d      = 14'd1;
                    bit_cnt_d = 4'd1;
                    div_d     = LoadFirst;
                end
            end
            StCapture: begin
                if (tick) begin
                    sr_d      = {sr_q[12:0], morse_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    div_d     = LoadUnit;
                end else begin
                    div_d = div_q - CNT_W'(1);
                end
            end
            StDecode: begin
                letter_d = dec_hit ? dec_letter : 3'd0;
                code_d   = sr_q;
                valid_d  = 1'b1;
                error_d  = ~dec_hit;
                div_d    = LoadUnit;
            end
            StGap: begin
                if (morse_s) begin
                    div_d = LoadUnit;
                end else if (div_q != '0) begin
                    div_d = div_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy   = (state_q != StIdle);
        letter = letter_q;
        code   = code_q;
        valid  = valid_q;
        error  = error_q;
    end

endmodule
